// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler: pops one packet at a time and routes it by its top-byte destination ID.
// Define SELF_SEND_EN to allow self-addressed packets and to include the source in broadcasts.
module bus_rr_scheduler #(
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [$clog2(drvrs)-1:0]   grant_id,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned IdW = $clog2(drvrs);

  typedef enum logic [1:0] {StIdle, StPop, StRoute, StPush} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     g_q, g_d, last_q, last_d;
  logic [pckg_sz-1:0] pkt_q, pkt_d, d_push_q, d_push_d;
  logic [drvrs-1:0]   mask_q, mask_d, route_mask;
  logic [15:0]        drop_q, drop_d;
  logic               found;
  logic [IdW-1:0]     winner, scan_idx;
  logic [7:0]         dest;

  assign dest = pkt_q[pckg_sz-1 -: 8];

  // Scan starts just past the last served device and wraps once around.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= drvrs; k++) begin
      scan_idx = IdW'((32'(last_q) + k) % drvrs);
      if (!found && pndng[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // An empty mask means the packet is dropped.
  always_comb begin
    route_mask = '0;
    for (int unsigned i = 0; i < drvrs; i++) begin
`ifdef SELF_SEND_EN
      if (dest == broadcast) begin
        route_mask[i] = 1'b1;
      end else if (32'(dest) == i) begin
        route_mask[i] = 1'b1;
      end
`else
      if (dest == broadcast) begin
        route_mask[i] = (i != 32'(g_q));
      end else if ((32'(dest) == i) && (i != 32'(g_q))) begin
        route_mask[i] = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    last_d   = last_q;
    pkt_d    = pkt_q;
    mask_d   = mask_q;
    drop_d   = drop_q;
    d_push_d = d_push_q;
    pop      = '0;
    push     = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          g_d     = winner;
          state_d = StPop;
        end
      end
      StPop: begin
        pop[g_q] = 1'b1;
        pkt_d    = D_pop[32'(g_q)*pckg_sz +: pckg_sz];
        state_d  = StRoute;
      end
      StRoute: begin
        if (route_mask == '0) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          last_d  = g_q;
          state_d = StIdle;
        end else begin
          mask_d   = route_mask;
          d_push_d = pkt_q;
          state_d  = StPush;
        end
      end
      StPush: begin
        push    = mask_q;
        last_d  = g_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      g_q      <= '0;
      last_q   <= IdW'(drvrs - 1);
      pkt_q    <= '0;
      mask_q   <= '0;
      drop_q   <= '0;
      d_push_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_q   <= last_d;
      pkt_q    <= pkt_d;
      mask_q   <= mask_d;
      drop_q   <= drop_d;
      d_push_q <= d_push_d;
    end
  end

  assign D_push   = d_push_q;
  assign grant_id = g_q;
  assign busy     = (state_q != StIdle);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler with four 16-bit device ports.
module tb_bus_rr_scheduler;

`ifdef SELF_SEND_EN
  localparam bit SelfEn = 1'b1;
`else
  localparam bit SelfEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] D_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [15:0] D_push;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] drop_cnt;

  int checks = 0;
  int passes = 0;

  // Reference state: last served device, drop count, last bus value.
  int          m_last;
  int          m_drop;
  logic [15:0] m_dpush;

  bus_rr_scheduler #(
    .drvrs(4),
    .pckg_sz(16),
    .broadcast(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pndng(pndng),
    .D_pop(D_pop),
    .pop(pop),
    .push(push),
    .D_push(D_push),
    .grant_id(grant_id),
    .busy(busy),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [3:0] p, input int last);
    int j;
    for (int k = 1; k <= 4; k++) begin
      j = (last + k) % 4;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [15:0] pkt, input int src);
    int         dest;
    logic [3:0] m;
    dest = int'(pkt[15:8]);
    m    = 4'b0000;
    if (dest == 255) begin
      m = 4'b1111;
      if (!SelfEn) m[src] = 1'b0;
    end else if (dest < 4 && (SelfEn || dest != src)) begin
      m[dest] = 1'b1;
    end
    return m;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic txn(input logic [3:0] p, input logic [63:0] data, input string tag,
                     output logic [3:0] o_push, output logic [15:0] o_dpush,
                     output logic [1:0] o_gid);
    int         g;
    logic [15:0] pkt;
    logic [3:0]  m;
    pndng = p;
    D_pop = data;
    g = rr_pick(p, m_last);
    @(negedge clk);
    o_gid = grant_id;
    if (g < 0) begin
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_pop"}, pop, 0);
      o_push  = push;
      o_dpush = D_push;
      return;
    end
    pkt = data[g*16 +: 16];
    m   = exp_mask(pkt, g);
    check({tag, "_pop"}, pop, 32'(1) << g);
    check({tag, "_gid"}, grant_id, g);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_push_in_pop"}, push, 0);
    check({tag, "_dpush_hold"}, D_push, m_dpush);
    @(negedge clk);
    check({tag, "_route_pop"}, pop, 0);
    check({tag, "_route_push"}, push, 0);
    @(negedge clk);
    o_push  = push;
    o_dpush = D_push;
    if (m != 4'b0000) m_dpush = pkt;
    else m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
    m_last = g;
    check({tag, "_push"}, push, m);
    check({tag, "_dpush"}, D_push, m_dpush);
    check({tag, "_drop"}, drop_cnt, m_drop);
    check({tag, "_pop_off"}, pop, 0);
    if (m != 4'b0000) begin
      @(negedge clk);
      check({tag, "_push_off"}, push, 0);
    end
    check({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] od;
    logic [1:0]  og;
    logic [1:0]  prev;
    int          serve[4];
    logic [63:0] rdata;
    logic [7:0]  dst;

    reset = 1'b0;
    pndng = '0;
    D_pop = '0;
    m_last = 3;
    m_drop = 0;
    m_dpush = '0;
    repeat (3) @(negedge clk);
    check("rst_pop", pop, 0);
    check("rst_push", push, 0);
    check("rst_dpush", D_push, 0);
    check("rst_gid", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    reset = 1'b1;

    // Single send: device 0 to device 2.
    txn(4'b0001, 64'h0000_0000_0000_02AB, "single", op, od, og);
    check("single_gid_const", og, 0);
    check("single_push_const", op, 4'b0100);
    check("single_dpush_const", od, 16'h02AB);
    check("single_drop_const", drop_cnt, 0);

    // Fairness with every device pending; last served is device 0.
    for (int i = 0; i < 4; i++) serve[i] = 0;
    prev = 2'd0;
    for (int i = 0; i < 16; i++) begin
      txn(4'b1111, 64'h0044_0333_0222_0111, "fair", op, od, og);
      check("fair_order", og, (i + 1) % 4);
      check("fair_no_repeat", og != prev, 1);
      serve[og]++;
      prev = og;
    end
    for (int i = 0; i < 4; i++) check("fair_count", serve[i], 4);

    // Broadcast from device 2.
    txn(4'b0100, 64'h0000_FF55_0000_0000, "bcast", op, od, og);
    check("bcast_push_const", op, SelfEn ? 4'b1111 : 4'b1011);
    check("bcast_dpush_const", od, 16'hFF55);

    // Out-of-range ID, then self-send from device 1.
    txn(4'b0010, 64'h0000_0000_0700_0000, "drop_range", op, od, og);
    check("drop_range_push", op, 0);
    txn(4'b0010, 64'h0000_0000_0100_0000, "drop_self", op, od, og);
    check("drop_self_push", op, SelfEn ? 4'b0010 : 4'b0000);
    check("drop_cnt_const", drop_cnt, SelfEn ? 1 : 2);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < 4; d++) begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3: dst = 8'(d + $urandom_range(0, 3)) & 8'h03;
          4:          dst = 8'hFF;
          default:    dst = 8'($urandom_range(0, 255));
        endcase
        rdata[d*16 +: 16] = {dst, 8'($urandom_range(0, 255))};
      end
      txn(4'($urandom_range(0, 15)), rdata, "rand", op, od, og);
    end

    // Saturation: preload the counter just below its ceiling.
    pndng = '0;
    @(negedge clk);
    force dut.drop_q = 16'hFFFE;
    @(negedge clk);
    release dut.drop_q;
    m_drop = 65534;
    check("sat_preload", drop_cnt, 16'hFFFE);
    txn(4'b0010, 64'h0000_0000_0700_0000, "sat1", op, od, og);
    check("sat1_const", drop_cnt, 16'hFFFF);
    txn(4'b0010, 64'h0000_0000_0700_0000, "sat2", op, od, og);
    check("sat2_const", drop_cnt, 16'hFFFF);

    // Reset in the cycle after pop aborts the transaction.
    pndng = 4'b0001;
    D_pop = 64'h0000_0000_0000_02AB;
    @(negedge clk);
    check("abort_pop", pop, 32'(1) << rr_pick(4'b0001, m_last));
    @(posedge clk);
    #2;
    reset = 1'b0;
    pndng = '0;
    #1;
    check("abort_pop_off", pop, 0);
    check("abort_push_off", push, 0);
    check("abort_dpush", D_push, 0);
    check("abort_gid", grant_id, 0);
    check("abort_busy", busy, 0);
    check("abort_drop", drop_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_push", push, 0);
    end
    reset = 1'b1;
    m_last = 3;
    m_drop = 0;
    m_dpush = '0;
    txn(4'b1111, 64'h0044_0333_0222_0111, "post_rst", op, od, og);
    check("post_rst_gid", og, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
